// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared types and defaults for tdm_demux (optional parity: TDM_DEMUX_PARITY_EN)
package tdm_demux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_CH_W  = 2;

    localparam string PARITY_MACRO = "TDM_DEMUX_PARITY_EN";
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/tdm_ch_decode.sv
// rtl/tdm_ch_decode.sv - channel index plus write strobe to one-hot shadow write-enable
module tdm_ch_decode
    import tdm_demux_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int CH_W = DEF_CH_W
) (
    input  logic [CH_W-1:0] idx_i,
    input  logic            we_i,
    output logic [NCH-1:0]  wen_o
);

    always_comb begin
        wen_o = '0;
        for (int k = 0; k < NCH; k++) begin
            wen_o[k] = we_i && (idx_i == CH_W'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM frame demultiplexer with double-buffered frame output (optional parity: TDM_DEMUX_PARITY_EN)
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int CH_W  = DEF_CH_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sof,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                   in_par,
    output logic                   par_err,
`endif
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic                   out_valid,
    output logic [CH_W-1:0]        ch_idx,
    output logic                   locked,
    output logic                   sync_err
);

    state_e               state_q;
    logic [CH_W-1:0]      ch_idx_q;
    logic [WIDTH-1:0]     shadow_q [NCH-1];
    logic [NCH*WIDTH-1:0] out_data_q;
    logic [NCH*WIDTH-1:0] frame_d;
    logic                 out_valid_q;
    logic                 sync_err_q;

    logic                 run;
    logic                 sof_slip;
    logic                 sof_miss;
    logic                 wr_en;
    logic [CH_W-1:0]      wr_idx;
    logic [NCH-1:0]       wen;
    logic                 frame_done;

    assign run      = (state_q == RUN);
    assign sof_slip = in_valid & run & in_sof & (ch_idx_q != '0);
    assign sof_miss = in_valid & run & ~in_sof & (ch_idx_q == '0);
    // Any accepted sof restarts the frame at slot 0; otherwise only mid-frame words in RUN are stored.
    assign wr_idx   = in_sof ? '0 : ch_idx_q;
    assign wr_en    = in_valid & (in_sof | (run & (ch_idx_q != '0)));

    tdm_ch_decode #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_decode (
        .idx_i (wr_idx),
        .we_i  (wr_en),
        .wen_o (wen)
    );

    // The last slot is never stored; its word goes straight into the delivered frame.
    assign frame_done = wen[NCH-1];

    always_comb begin
        frame_d = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            frame_d[k*WIDTH +: WIDTH] = shadow_q[k];
        end
        frame_d[(NCH-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            ch_idx_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                if (wen[k]) begin
                    shadow_q[k] <= in_data;
                end
            end
            if (sof_miss) begin
                state_q    <= HUNT;
                ch_idx_q   <= '0;
                sync_err_q <= 1'b1;
            end else if (wr_en && in_sof) begin
                state_q    <= RUN;
                ch_idx_q   <= CH_W'(1);
                sync_err_q <= sof_slip;
            end else if (frame_done) begin
                ch_idx_q    <= '0;
                out_data_q  <= frame_d;
                out_valid_q <= 1'b1;
            end else if (wr_en) begin
                ch_idx_q <= ch_idx_q + CH_W'(1);
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic word_bad;
    logic par_q;
    logic par_err_q;

    assign word_bad = (^in_data) ^ in_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else if (sof_miss) begin
            par_q <= 1'b0;
        end else if (wr_en && in_sof) begin
            par_q <= word_bad;
        end else if (frame_done) begin
            par_err_q <= par_q | word_bad;
            par_q     <= 1'b0;
        end else if (wr_en) begin
            par_q <= par_q | word_bad;
        end
    end

    assign par_err = par_err_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ch_idx    = ch_idx_q;
    assign locked    = run;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux (parity checks with TDM_DEMUX_PARITY_EN)
`timescale 1ns/1ps
module tb_tdm_demux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_sof   = 1'b0;
    logic [W-1:0]   in_data  = '0;
    logic [N*W-1:0] out_data;
    logic           out_valid;
    logic [CW-1:0]  ch_idx;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           in_par = 1'b0;
    logic           par_err;
`endif

    tdm_demux #(.WIDTH(W), .NCH(N), .CH_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
        .in_par    (in_par),
        .par_err   (par_err),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .ch_idx    (ch_idx),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] data;
        logic           par;
    } frame_t;

    int             checks   = 0;
    int             failures = 0;
    bit             done     = 1'b0;
    frame_t         frame_q[$];
    logic [W-1:0]   m_words[$];
    bit             m_bad[$];
    bit             m_locked = 1'b0;
    bit             exp_ov   = 1'b0;
    bit             exp_se   = 1'b0;
    logic [N*W-1:0] exp_last = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of words collected since the last accepted sof.
    task automatic model_step(bit sof, logic [W-1:0] d, bit bad);
        frame_t f;
        if (!m_locked) begin
            if (sof) begin
                m_words.delete(); m_bad.delete();
                m_words.push_back(d); m_bad.push_back(bad);
                m_locked = 1'b1;
            end
        end else if (sof) begin
            if (m_words.size() != 0) exp_se = 1'b1;
            m_words.delete(); m_bad.delete();
            m_words.push_back(d); m_bad.push_back(bad);
        end else if (m_words.size() == 0) begin
            exp_se   = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_words.push_back(d); m_bad.push_back(bad);
            if (m_words.size() == N) begin
                f.data = '0;
                f.par  = 1'b0;
                for (int k = 0; k < N; k++) begin
                    f.data[k*W +: W] = m_words[k];
                    f.par = f.par | m_bad[k];
                end
                frame_q.push_back(f);
                exp_ov = 1'b1;
                m_words.delete(); m_bad.delete();
            end
        end
    endtask

    task automatic drive(bit v, bit sof, logic [W-1:0] d, bit bad);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
        in_par   = (^d) ^ bad;
`endif
        @(posedge clk);
        exp_ov = 1'b0;
        exp_se = 1'b0;
        if (v) model_step(sof, d, bad);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        m_words.delete(); m_bad.delete();
        m_locked = 1'b0;
        exp_ov   = 1'b0;
        exp_se   = 1'b0;
        exp_last = '0;
        frame_q.delete();
        #1;
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_ch_idx", 64'(ch_idx), 64'h0);
        chk("rst_sync_err", 64'(sync_err), 64'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (!done) begin
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("sync_err", 64'(sync_err), 64'(exp_se));
            chk("locked", 64'(locked), 64'(m_locked));
            chk("ch_idx", 64'(ch_idx), 64'(m_words.size()));
            if (out_valid) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%0h expected=none at %0t", out_data, $time);
                end else begin
                    f = frame_q.pop_front();
                    exp_last = f.data;
`ifdef TDM_DEMUX_PARITY_EN
                    chk("par_err", 64'(par_err), 64'(f.par));
`endif
                end
            end
            chk("out_data", 64'(out_data), 64'(exp_last));
        end
    end

    initial begin
        bit sof;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_out_data", 64'(out_data), 64'h0);
        chk("init_out_valid", 64'(out_valid), 64'h0);
        chk("init_locked", 64'(locked), 64'h0);
        chk("init_ch_idx", 64'(ch_idx), 64'h0);
        chk("init_sync_err", 64'(sync_err), 64'h0);
        #1 rst_n = 1'b1;

        drive(1, 1, 8'h11, 0); drive(1, 0, 8'h22, 0); drive(1, 0, 8'h33, 0); drive(1, 0, 8'h44, 0);
        idle(2);
        chk("frame1_data", 64'(out_data), 64'h44332211);

        drive(1, 0, 8'hAA, 0); drive(1, 0, 8'hBB, 0);
        drive(1, 1, 8'h01, 0); drive(1, 0, 8'h02, 0); drive(1, 0, 8'h03, 0); drive(1, 0, 8'h04, 0);
        idle(2);

        drive(1, 1, 8'h11, 0); drive(1, 0, 8'h22, 0); drive(1, 1, 8'h99, 0);
        drive(1, 0, 8'h0A, 0); drive(1, 0, 8'h0B, 0); drive(1, 0, 8'h0C, 0);
        idle(2);
        chk("early_sof_data", 64'(out_data), 64'h0C0B0A99);

        drive(1, 1, 8'h21, 0); drive(1, 0, 8'h22, 0); drive(1, 0, 8'h23, 0); drive(1, 0, 8'h24, 0);
        drive(1, 0, 8'h55, 0);
        idle(2);

        drive(1, 1, 8'h31, 0); idle(2); drive(1, 0, 8'h32, 0); idle(1);
        drive(1, 0, 8'h33, 0); idle(3); drive(1, 0, 8'h34, 0);
        idle(1);
        drive(1, 1, 8'h41, 0); drive(1, 0, 8'h42, 0);
        pulse_reset();
        idle(5);
        drive(1, 1, 8'h51, 0); drive(1, 0, 8'h52, 0); drive(1, 0, 8'h53, 0); drive(1, 0, 8'h54, 0);
        idle(2);

`ifdef TDM_DEMUX_PARITY_EN
        drive(1, 1, 8'h11, 0); drive(1, 0, 8'h22, 0); drive(1, 0, 8'h33, 1); drive(1, 0, 8'h44, 0);
        idle(1);
        drive(1, 1, 8'h11, 0); drive(1, 0, 8'h22, 0); drive(1, 0, 8'h33, 0); drive(1, 0, 8'h44, 0);
        idle(2);
`endif

        for (int i = 0; i < 600; i++) begin
            if (m_words.size() == 0) sof = ($urandom % 10) != 0;
            else                     sof = ($urandom % 20) == 0;
            drive(($urandom % 4) != 0, sof, W'($urandom), ($urandom % 10) == 0);
        end
        idle(3);

        chk("frames_pending", 64'(frame_q.size()), 64'h0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
